// File: rtl/fir_engine.sv
// FIR / scalar-product datapath: joins operand streams a and b, multiplies them,
// and either accumulates len products into one shifted result or emits every product.

package fir_pkg;
  localparam int FIR_CNT_LEN = 1024;
  localparam int CNT_W       = $clog2(FIR_CNT_LEN) + 1;

  typedef struct packed {
    logic             clear;
    logic             enable;
    logic             simple_mul;
    logic             start;
    logic [4:0]       shift;
    logic [CNT_W-1:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             acc_valid;
  } flags_engine_t;
endpackage

module fir_engine
  import fir_pkg::*;
#(
  parameter int FIR_CNT_LEN = fir_pkg::FIR_CNT_LEN
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  ctrl_engine_t  ctrl_i,
  output flags_engine_t flags_o,
  input  logic          a_valid_i,
  input  logic [31:0]   a_data_i,
  output logic          a_ready_o,
  input  logic          b_valid_i,
  input  logic [31:0]   b_data_i,
  output logic          b_ready_o,
  output logic          d_valid_o,
  output logic [31:0]   d_data_o,
  input  logic          d_ready_i
);

  localparam int CW = $clog2(FIR_CNT_LEN) + 1;

  logic               adv;
  logic               hs;
  logic               vm_q;
  logic signed [63:0] prod_q;
  logic signed [63:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic [CW-1:0]      cnt_eff;
  logic [CW-1:0]      cnt_next;
  logic [CW-1:0]      len_eff;
  logic signed [63:0] acc_new;
  logic signed [63:0] shift_src;
  logic signed [63:0] shifted;
  logic               emit;

  // A stalled output freezes the whole pipeline, so ready depends combinationally on d_ready_i.
  assign adv       = ctrl_i.enable & (~d_valid_o | d_ready_i);
  assign hs        = adv & a_valid_i & b_valid_i;
  assign a_ready_o = hs;
  assign b_ready_o = hs;

  assign a_ext = {{32{a_data_i[31]}}, a_data_i};
  assign b_ext = {{32{b_data_i[31]}}, b_data_i};

  always_comb begin
    // A coincident start makes the current product the first of a fresh accumulation.
    cnt_eff   = ctrl_i.start ? '0 : cnt_q;
    acc_new   = (cnt_eff == '0) ? prod_q : acc_q + prod_q;
    cnt_next  = cnt_eff + CW'(1);
    len_eff   = (ctrl_i.len == '0) ? CW'(1) : CW'(ctrl_i.len);
    emit      = (cnt_next >= len_eff);
    shift_src = ctrl_i.simple_mul ? prod_q : acc_new;
    shifted   = shift_src >>> ctrl_i.shift;
  end

  always_comb begin
    flags_o           = '0;
    flags_o.cnt       = CNT_W'(cnt_q);
    flags_o.acc_valid = d_valid_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vm_q      <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      d_valid_o <= 1'b0;
      d_data_o  <= '0;
    end else if (ctrl_i.clear) begin
      vm_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      d_valid_o <= 1'b0;
    end else begin
      if (d_valid_o && d_ready_i)
        d_valid_o <= 1'b0;
      if (ctrl_i.start) begin
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (adv) begin
        prod_q <= a_ext * b_ext;
        vm_q   <= hs;
      end
      if (vm_q && adv) begin
        if (ctrl_i.simple_mul) begin
          d_data_o  <= shifted[31:0];
          d_valid_o <= 1'b1;
        end else begin
          acc_q <= acc_new;
          if (emit) begin
            d_data_o  <= shifted[31:0];
            d_valid_o <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_engine.sv
// Bench for fir_engine: directed vectors, expected results queued at issue time
// and checked by a separate output monitor.

module tb_fir_engine;
  import fir_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [31:0]   a_data, b_data;
  logic          d_valid, d_ready;
  logic [31:0]   d_data;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_q[$];

  fir_engine dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ctrl_i    (ctrl),
    .flags_o   (flags),
    .a_valid_i (a_valid),
    .a_data_i  (a_data),
    .a_ready_o (a_ready),
    .b_valid_i (b_valid),
    .b_data_i  (b_data),
    .b_ready_o (b_ready),
    .d_valid_o (d_valid),
    .d_data_o  (d_data),
    .d_ready_i (d_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // Output monitor: a transfer happens on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_d: got %h want no output", d_data);
      end else begin
        check("d_data", d_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    a_data  = a;
    b_data  = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_total++;
    $display("FAIL send_timeout: got no ready want ready within 50 cycles");
  endtask

  task automatic idle_in();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    ctrl    = '0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    d_ready = 1'b1;
    #12;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_data", d_data, 32'd0);
    check("rst_cnt", 32'(flags.cnt), 32'd0);
    check("rst_acc_valid", 32'(flags.acc_valid), 32'd0);
    @(posedge clk); #1;
    rst         = 1'b0;
    ctrl.enable = 1'b1;

    // Normal accumulation: 1*5+2*6+3*7+4*8 = 70
    ctrl.len = 11'd4;
    exp_q.push_back(32'd70);
    send(32'd1, 32'd5);
    send(32'd2, 32'd6);
    check("acc_cnt1", 32'(flags.cnt), 32'd1);
    send(32'd3, 32'd7);
    check("acc_cnt2", 32'(flags.cnt), 32'd2);
    send(32'd4, 32'd8);
    check("acc_cnt3", 32'(flags.cnt), 32'd3);
    idle_in();
    tick(1);
    check("acc_cnt0", 32'(flags.cnt), 32'd0);
    check("acc_valid_rise", 32'(flags.acc_valid), 32'd1);
    check("acc_d70", d_data, 32'd70);
    tick(1);
    check("acc_valid_fall", 32'(flags.acc_valid), 32'd0);

    // Simple multiply with shift
    ctrl.simple_mul = 1'b1;
    ctrl.shift      = 5'd2;
    exp_q.push_back(32'hFFFF_FFF7);
    send(32'hFFFF_FFF4, 32'd3);
    exp_q.push_back(32'd1);
    send(32'd7, 32'd1);
    idle_in();
    tick(3);
    check("simple_cnt", 32'(flags.cnt), 32'd0);
    ctrl.simple_mul = 1'b0;
    ctrl.shift      = 5'd0;

    // Backpressure
    ctrl.len = 11'd1;
    d_ready  = 1'b0;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd30);
    send(32'd1, 32'd10);
    send(32'd2, 32'd10);
    a_data = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_a_ready_low", 32'(a_ready), 32'd0);
      check("bp_d_held", d_data, 32'd10);
    end
    @(posedge clk); #1;
    d_ready = 1'b1;
    send(32'd3, 32'd10);
    idle_in();
    tick(4);

    // Wide arithmetic
    ctrl.len   = 11'd2;
    ctrl.shift = 5'd31;
    exp_q.push_back(32'hFFFF_FFFC);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    idle_in();
    tick(3);
    ctrl.shift = 5'd0;
    exp_q.push_back(32'h0000_0002);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    idle_in();
    tick(3);

    // Clear mid-run
    ctrl.len = 11'd4;
    send(32'd5, 32'd5);
    send(32'd5, 32'd5);
    idle_in();
    tick(2);
    check("clr_pre_cnt", 32'(flags.cnt), 32'd2);
    ctrl.clear = 1'b1;
    tick(1);
    ctrl.clear = 1'b0;
    check("clr_cnt", 32'(flags.cnt), 32'd0);
    check("clr_d_valid", 32'(d_valid), 32'd0);
    exp_q.push_back(32'd8);
    for (int i = 0; i < 4; i++) send(32'd1, 32'd2);
    idle_in();
    tick(3);

    // Start coincident with a stage-A product: 2*3 restarts the accumulation
    send(32'd100, 32'd1);
    send(32'd2, 32'd3);
    idle_in();
    ctrl.start = 1'b1;
    tick(1);
    ctrl.start = 1'b0;
    check("start_cnt", 32'(flags.cnt), 32'd1);
    exp_q.push_back(32'd9);
    for (int i = 0; i < 3; i++) send(32'd1, 32'd1);
    idle_in();
    tick(3);

    // len=0 behaves as len=1
    ctrl.len = 11'd0;
    exp_q.push_back(32'd9);
    send(32'd3, 32'd3);
    exp_q.push_back(32'd9);
    send(32'd3, 32'd3);
    idle_in();
    tick(3);

    // Asynchronous reset mid-accumulation
    ctrl.len = 11'd4;
    send(32'd1, 32'd1);
    send(32'd1, 32'd1);
    idle_in();
    tick(2);
    check("rst_mid_pre_cnt", 32'(flags.cnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_cnt", 32'(flags.cnt), 32'd0);
    check("rst_mid_d_data", d_data, 32'd0);
    check("rst_mid_d_valid", 32'(d_valid), 32'd0);
    check("rst_mid_acc_valid", 32'(flags.acc_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
